// File: rtl/if_id_stage_buf_pkg.sv
// Shared types for the IF/ID stage buffer: occupancy encoding, default NOP and payload layout.
package if_id_stage_buf_pkg;

    // Bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_BOTH  = 2'b11
    } occ_e;

    // MIPS sll $0,$0,0
    localparam logic [31:0] NOP_DEFAULT = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } payload32_t;

endpackage

// File: rtl/if_id_stage_buf_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stage_buf.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer,
// hazard stall, branch flush with NOP insertion and saturating stall/flush counters.
module if_id_stage_buf
    import if_id_stage_buf_pkg::*;
#(
    parameter int                 PC_W     = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 CNT_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_DEFAULT)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [PC_W-1:0]    PCAddResult,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [PC_W-1:0]    ID_PCAddResult,
    output logic [INSTR_W-1:0] ID_Instruction,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } payload_t;

    localparam payload_t NOP_BEAT = '{pc: '0, instr: NOP_WORD};

    occ_e     state_q;
    payload_t main_q, skid_q, in_beat;
    logic     skid_vld, take_in, take_out;

    assign in_beat   = '{pc: PCAddResult, instr: Instruction};
    assign out_valid = state_q[0];
    assign skid_vld  = state_q[1];
    // Gated by Reset so the stage reports not-ready during reset and ready
    // in the very first cycle after release.
    assign in_ready  = Reset & ~skid_vld;
    assign take_in   = in_valid & in_ready;
    assign take_out  = out_valid & out_ready & ~stall;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_BEAT;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_BEAT;
            skid_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: if (take_in) begin
                    state_q <= ST_MAIN;
                    main_q  <= in_beat;
                end
                ST_MAIN: begin
                    if (take_in && take_out) begin
                        main_q <= in_beat;
                    end else if (take_in) begin
                        state_q <= ST_BOTH;
                        skid_q  <= in_beat;
                    end else if (take_out) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_BOTH: if (take_out) begin
                    state_q <= ST_MAIN;
                    main_q  <= skid_q;
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign ID_PCAddResult = main_q.pc;
    assign ID_Instruction = main_q.instr;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .inc_i  (out_valid & (stall | ~out_ready)),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .inc_i  (flush & (out_valid | skid_vld)),
        .cnt_o  (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Bench for if_id_stage_buf: directed scenarios then random traffic against a queue-based model.
module tb_if_id_stage_buf;
    import if_id_stage_buf_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] PCAddResult = '0, Instruction = '0;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] ID_PCAddResult, ID_Instruction;
    logic [15:0] stall_cnt, flush_cnt;
    // Narrow-counter instance sharing the same stimulus.
    logic        in_ready2, out_valid2;
    logic [31:0] ID_PCAddResult2, ID_Instruction2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    always #5 Clk = ~Clk;

    if_id_stage_buf u_dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Instruction(Instruction),
        .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .ID_PCAddResult(ID_PCAddResult),
        .ID_Instruction(ID_Instruction), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_stage_buf #(.CNT_W(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Instruction(Instruction),
        .in_valid(in_valid), .in_ready(in_ready2), .stall(stall), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid2), .ID_PCAddResult(ID_PCAddResult2),
        .ID_Instruction(ID_Instruction2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } beat_t;

    beat_t q[$];
    beat_t disp;
    int    m_stall, m_flush, m_stall2, m_flush2;
    int    n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    function void model_reset();
        q.delete();
        disp     = '{pc: 32'h0, ins: NOP_DEFAULT};
        m_stall  = 0;
        m_flush  = 0;
        m_stall2 = 0;
        m_flush2 = 0;
    endfunction

    // Next state of the reference after the coming clock edge.
    function void model_step();
        bit vis, tin, tout;
        if (!Reset) begin
            model_reset();
            return;
        end
        vis  = (q.size() > 0);
        tin  = in_valid && (q.size() < 2);
        tout = vis && out_ready && !stall;
        if (vis && (stall || !out_ready)) begin
            m_stall  = sat_inc(m_stall, 65535);
            m_stall2 = sat_inc(m_stall2, 3);
        end
        if (flush) begin
            if (vis) begin
                m_flush  = sat_inc(m_flush, 65535);
                m_flush2 = sat_inc(m_flush2, 3);
            end
            q.delete();
            disp = '{pc: 32'h0, ins: NOP_DEFAULT};
        end else begin
            if (tout) void'(q.pop_front());
            if (tin) q.push_back('{pc: PCAddResult, ins: Instruction});
            if (q.size() > 0) disp = q[0];
        end
    endfunction

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(Reset && q.size() < 2));
        chk("id_pc", 64'(ID_PCAddResult), 64'(disp.pc));
        chk("id_instr", 64'(ID_Instruction), 64'(disp.ins));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        chk("out_valid2", 64'(out_valid2), 64'(q.size() > 0));
        chk("stall_cnt2", 64'(stall_cnt2), 64'(m_stall2));
        chk("flush_cnt2", 64'(flush_cnt2), 64'(m_flush2));
    endtask

    task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                       input bit st, input bit fl, input bit ordy);
        in_valid    = iv;
        PCAddResult = pc;
        Instruction = ins;
        stall       = st;
        flush       = fl;
        out_ready   = ordy;
        model_step();
        @(posedge Clk);
        @(negedge Clk);
        compare_all();
    endtask

    localparam logic [31:0] IA = 32'h2002000A, IB = 32'h20030005, IC = 32'h8C040010;

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        compare_all();
        Reset = 1'b1;
        #1 compare_all();

        // Streaming with decode always ready
        cyc(1, 32'h4, IA, 0, 0, 1);
        cyc(1, 32'h8, IB, 0, 0, 1);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);

        // Backpressure fills the skid, then drains in order
        cyc(1, 32'h4, IA, 0, 0, 0);
        cyc(1, 32'h8, IB, 0, 0, 0);
        cyc(1, 32'hC, IC, 0, 0, 0);
        cyc(1, 32'hC, IC, 0, 0, 1);
        cyc(1, 32'hC, IC, 0, 0, 1);
        repeat (3) cyc(0, 32'h0, 32'h0, 0, 0, 1);

        // Stall hold
        cyc(1, 32'h4, IA, 0, 0, 0);
        repeat (4) cyc(0, 32'h0, 32'h0, 1, 0, 1);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);

        // Flush from BOTH with a beat offered
        cyc(1, 32'h4, IA, 0, 0, 0);
        cyc(1, 32'h8, IB, 0, 0, 0);
        cyc(1, 32'h10, 32'hDEADBEEF, 0, 1, 0);
        repeat (2) cyc(0, 32'h0, 32'h0, 0, 0, 1);

        // Asynchronous reset with BOTH full
        cyc(1, 32'h4, IA, 0, 0, 0);
        cyc(1, 32'h8, IB, 0, 0, 0);
        #2 Reset = 1'b0;
        model_reset();
        #1 compare_all();
        cyc(1, 32'h4, IA, 0, 0, 1);
        @(negedge Clk);
        Reset = 1'b1;
        #1 compare_all();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 70, $urandom, $urandom,
                $urandom_range(99) < 20, $urandom_range(99) < 5,
                $urandom_range(99) < 70);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_stage_buf.md
Name: if_id_stage_buf

Overview:
- Parametrised successor to the fetch/decode pipeline register. Carries {PC+4, instruction} from IF to ID.
- Adds a valid/ready handshake, a 2-entry skid buffer, hazard stall, branch flush with NOP insertion, and saturating stall/flush counters.
- Sits between the PC adder / instruction memory and the decode stage.

Parameters:
PC_W, 32, width of the PCAddResult field
INSTR_W, 32, width of the instruction field
CNT_W, 16, width of each saturating performance counter
NOP_WORD, 0, value loaded into the instruction field on reset or flush

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
PCAddResult  in  PC_W  PC+4 from fetch
Instruction  in  INSTR_W  fetched instruction
in_valid  in  1  fetch beat valid
in_ready  out  1  stage can accept a beat
stall  in  1  hazard-unit hold; blocks the downstream transfer
flush  in  1  branch/jump taken; discard all held beats
out_ready  in  1  decode can accept a beat
out_valid  out  1  ID_* outputs hold a live beat
ID_PCAddResult  out  PC_W  registered PC+4
ID_Instruction  out  INSTR_W  registered instruction
stall_cnt  out  CNT_W  saturating count of stalled cycles
flush_cnt  out  CNT_W  saturating count of effective flushes

Behaviour:
- Reset (Reset=0, asynchronous) sets the following, and it takes precedence over everything:
  - out_valid=0, ID_PCAddResult=0, ID_Instruction=NOP_WORD.
  - Skid entry invalid with zeroed payload; both counters 0; in_ready=0 while Reset=0.
- Internal state is a main entry (drives the ID_* outputs) plus a skid entry. Occupancy states: EMPTY, MAIN, BOTH.
- Definitions:
  - take_out = out_valid & out_ready & ~stall
  - take_in = in_valid & in_ready
- in_ready = ~skid_valid, registered. It is 1 in EMPTY and MAIN, 0 in BOTH, and 1 in the first cycle after reset release.
- Transitions (flush=0):
  - EMPTY: take_in -> MAIN; main loads the input. Latency is 1 cycle from accept to out_valid.
  - MAIN:
    - take_in & take_out -> MAIN; main loads the input.
    - take_in & ~take_out -> BOTH; skid loads the input.
    - ~take_in & take_out -> EMPTY.
    - Otherwise hold.
  - BOTH (in_ready=0):
    - take_out -> MAIN; main loads the skid entry.
    - Otherwise hold.
- Ordering is strict FIFO; no beat is ever dropped or duplicated without a flush.
- Flush=1 at a clock edge has priority over stall and all handshakes:
  - Both entries are invalidated. The state goes to EMPTY next cycle.
  - ID_Instruction becomes NOP_WORD and ID_PCAddResult becomes 0.
  - Any beat offered in the same cycle is discarded, even if in_ready=1.
  - A beat taken by decode in the flush cycle counts as delivered.
- Stall=1 (flush=0): the main entry is held regardless of out_ready. Upstream may still fill the skid entry.
- While out_valid=0, the payload holds its last value (NOP after reset or flush). Decode must gate on out_valid.
- stall_cnt: +1 on each cycle with out_valid & (stall | ~out_ready). Saturates at 2^CNT_W-1.
- flush_cnt: +1 on each flush cycle where at least one entry is valid. Saturates the same way.
- Both counters clear only on reset; they are not cleared by flush.
- Reset asserted mid-operation: all state is lost immediately. The first accept is possible in the cycle after reset deasserts.

Decomposition:
- Shared package holds:
  - state encoding: EMPTY=2'b00, MAIN=2'b01, BOTH=2'b11
  - default NOP_WORD constant (32'h0, the MIPS sll $0 encoding)
  - a payload struct {pc, instr}
- One sub-module is natural: sat_counter (CNT_W, increment enable, async active-low clear), instantiated twice.

Test Plan:
- Reset=0 for 3 cycles, then release -> out_valid=0, ID_Instruction=32'h0, in_ready=1, counters 0. Assert Reset=0 mid-stream with BOTH full -> outputs clear the same cycle.
- Stream in beats A=(32'h4, 32'h2002000A) and B=(32'h8, 32'h20030005) with out_ready=1 -> A appears 1 cycle after accept, B the next cycle, out_valid continuous.
- Set out_ready=0 and offer A, B, C -> A in main, B in skid, in_ready=0, C held upstream. Then out_ready=1 -> A, B, C emerge in order with no loss.
- Hold stall=1 for 4 cycles with A valid and out_ready=1 -> A held, stall_cnt=4. Release -> A transfers in the next cycle.
- In BOTH state, pulse flush with in_valid=1 -> next cycle out_valid=0, ID_Instruction=NOP_WORD, in_ready=1, flush_cnt=1, and the offered beat never appears.
- Set CNT_W=2 and stall for 6 cycles -> stall_cnt sticks at 3.
